// File: rtl/gpio_irq_wb_pkg.sv
// Shared definitions for the Wishbone GPIO/interrupt controller:
// register group offsets and the bank-index width helper.
package gpio_irq_wb_pkg;

   // Register group selected by the upper three address bits.
   typedef enum logic [2:0] {
      GPIO_GRP_DATA = 3'd0,
      GPIO_GRP_DIR  = 3'd1,
      GPIO_GRP_IE   = 3'd2,
      GPIO_GRP_TYPE = 3'd3,
      GPIO_GRP_POL  = 3'd4,
      GPIO_GRP_IS   = 3'd5,
      GPIO_GRP_RSV6 = 3'd6,
      GPIO_GRP_RSV7 = 3'd7
   } grp_e;

   // Width of the byte-bank index; a single bank still gets one address bit.
   function automatic int bank_bits(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/gpio_irq_wb_if.sv
// Classic-cycle Wishbone slave bus, 8-bit data.
interface gpio_irq_wb_if #(
   parameter int ADR_W = 5
);
   logic [ADR_W-1:0] wb_adr_i;
   logic [7:0]       wb_dat_i;
   logic             wb_we_i;
   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic [2:0]       wb_cti_i;
   logic [1:0]       wb_bte_i;
   logic             wb_ack_o;
   logic [7:0]       wb_dat_o;
   logic             wb_err_o;
   logic             wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/gpio_irq_wb_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs; chain clears on reset.
module gpio_sync #(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         wb_clk,
   input  logic         wb_rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] chain;

   // Shift the pin sample one stage per clock; stage 0 is the metastable one.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];
endmodule

// File: rtl/gpio_irq_wb.sv
// Wishbone GPIO controller: per-bit direction/output registers, synchronised
// inputs, and an edge/level interrupt unit with sticky write-1-to-clear status.
module gpio_irq_wb
   import gpio_irq_wb_pkg::*;
#(
   parameter int                GPIO_W      = 32,
   parameter int                SYNC_STAGES = 2,
   parameter logic [GPIO_W-1:0] DIR_RESET   = '0,
   parameter logic [GPIO_W-1:0] OUT_RESET   = '0
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   gpio_irq_wb_if.slave      wb,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              int_o
);
   localparam int NB       = GPIO_W / 8;
   localparam int BW       = bank_bits(NB);
   localparam int WB_ADR_W = 3 + BW;

   logic [WB_ADR_W-1:0] adr;
   grp_e                grp;
   logic [BW-1:0]       bsel;
   logic                req, wr;
   logic                ack_q;
   logic [7:0]          dat_q, rd_byte;

   logic [NB-1:0][7:0]  out_q, dir_q, ie_q, type_q, pol_q, is_q;
   logic [NB-1:0][7:0]  w1c, data_rd;
   logic [NB-1:0]       lane_we;

   logic [GPIO_W-1:0]   s, p;
   logic [GPIO_W-1:0]   edge_evt, lvl_evt, evt;
   logic                irq_q;

   // Burst signals are accepted but have no effect on classic cycles.
   logic unused_bus;
   assign unused_bus = ^{wb.wb_cti_i, wb.wb_bte_i};

   assign adr  = wb.wb_adr_i;
   assign grp  = grp_e'(adr[BW+2:BW]);
   assign bsel = adr[BW-1:0];

   // A request is taken only while no ack is outstanding, so a held strobe
   // is served every other cycle.
   assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wr  = req & wb.wb_we_i;

   // Per-byte-lane write strobe and write-1-to-clear mask; out-of-range
   // bank indices match no lane and are therefore ignored.
   for (genvar g = 0; g < NB; g++) begin : g_lane
      assign lane_we[g] = wr & (bsel == BW'(g));
      assign w1c[g]     = (lane_we[g] && grp == GPIO_GRP_IS) ? wb.wb_dat_i : 8'h00;
   end

   gpio_sync #(.W(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
      .wb_clk (wb_clk),
      .wb_rst (wb_rst),
      .d      (gpio_i),
      .q      (s)
   );

   // Configuration and output registers, written one byte lane at a time.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         out_q  <= OUT_RESET;
         dir_q  <= DIR_RESET;
         ie_q   <= '0;
         type_q <= '0;
         pol_q  <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (lane_we[b]) begin
               case (grp)
                  GPIO_GRP_DATA: out_q[b]  <= wb.wb_dat_i;
                  GPIO_GRP_DIR:  dir_q[b]  <= wb.wb_dat_i;
                  GPIO_GRP_IE:   ie_q[b]   <= wb.wb_dat_i;
                  GPIO_GRP_TYPE: type_q[b] <= wb.wb_dat_i;
                  GPIO_GRP_POL:  pol_q[b]  <= wb.wb_dat_i;
                  default: ;
               endcase
            end
         end
      end
   end

   // Events are evaluated for every bit, including outputs, which see
   // their own pin echo.
   assign edge_evt = (pol_q & s & ~p) | (~pol_q & ~s & p);
   assign lvl_evt  = (pol_q & s) | (~pol_q & ~s);
   assign evt      = (type_q & edge_evt) | (~type_q & lvl_evt);

   // Previous-sample register, sticky status (a new event beats a
   // simultaneous clear) and the registered interrupt line.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         p     <= '0;
         is_q  <= '0;
         irq_q <= 1'b0;
      end else begin
         p     <= s;
         is_q  <= (is_q & ~w1c) | evt;
         irq_q <= |(is_q & ie_q);
      end
   end

   // Driven bits read back the output register, inputs read the pin.
   assign data_rd = (dir_q & out_q) | (~dir_q & s);

   // Read mux; reserved groups and absent banks return zero.
   always_comb begin
      rd_byte = 8'h00;
      for (int b = 0; b < NB; b++) begin
         if (bsel == BW'(b)) begin
            case (grp)
               GPIO_GRP_DATA: rd_byte = data_rd[b];
               GPIO_GRP_DIR:  rd_byte = dir_q[b];
               GPIO_GRP_IE:   rd_byte = ie_q[b];
               GPIO_GRP_TYPE: rd_byte = type_q[b];
               GPIO_GRP_POL:  rd_byte = pol_q[b];
               GPIO_GRP_IS:   rd_byte = is_q[b];
               default:       rd_byte = 8'h00;
            endcase
         end
      end
   end

   // Single-cycle acknowledge with registered read data.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         ack_q <= 1'b0;
         dat_q <= 8'h00;
      end else begin
         ack_q <= req;
         if (req) dat_q <= rd_byte;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_err_o = 1'b0;
   assign wb.wb_rty_o = 1'b0;

   assign gpio_o  = out_q;
   assign gpio_oe = dir_q;
   assign int_o   = irq_q;
endmodule
